// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and helpers for the piso_tx serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    typedef logic [0:0] state_t;

    localparam state_t c_IDLE  = 1'b0;
    localparam state_t c_SHIFT = 1'b1;

    // Ceiling log2 for elaboration-time sizing; bounded loop keeps it synthesizable.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_bitcnt.sv
`default_nettype none
// ============================================================================
// Module      : piso_bitcnt
// Description : Loadable up-counter with synchronous clear and a terminal-count
//               flag at LAST; it holds at LAST rather than wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bitcnt #(
    parameter int CNT_W = 4,
    parameter int LAST  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != c_LAST)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_tc = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in/serial-out transmitter with valid/ready input.
//               Define PISO_PARITY_EN to append an even-parity bit per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int c_FRAME_LEN = WIDTH + 1;
`else
    localparam int c_FRAME_LEN = WIDTH;
`endif
    localparam int c_CNT_W = clog2(WIDTH + 1);

    state_t                 r_state;
    logic [c_FRAME_LEN-1:0] r_shreg;
    logic                   r_sout_valid;
    logic                   r_frame_start;
    logic                   r_busy;

    logic [c_FRAME_LEN-1:0] w_frame;
    logic [c_FRAME_LEN-1:0] w_shifted;
    logic                   w_in_shift;
    logic                   w_tc;
    logic                   w_accept;

    // The outgoing bit always sits at the shift-out end of r_shreg, so sout is
    // a register output and reads 0 whenever the register is cleared.
    generate
        if (MSB_FIRST) begin : g_msb_first
`ifdef PISO_PARITY_EN
            assign w_frame = {din, ^din};
`else
            assign w_frame = din;
`endif
            assign w_shifted = {r_shreg[c_FRAME_LEN-2:0], 1'b0};
            assign sout      = r_shreg[c_FRAME_LEN-1];
        end else begin : g_lsb_first
`ifdef PISO_PARITY_EN
            assign w_frame = {^din, din};
`else
            assign w_frame = din;
`endif
            assign w_shifted = {1'b0, r_shreg[c_FRAME_LEN-1:1]};
            assign sout      = r_shreg[0];
        end
    endgenerate

    assign w_in_shift = (r_state == c_SHIFT);
    assign din_ready  = ~rst & (~w_in_shift | w_tc);
    assign w_accept   = din_valid & din_ready;

    piso_bitcnt #(
        .CNT_W (c_CNT_W),
        .LAST  (c_FRAME_LEN - 1)
    ) u_bitcnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_in_shift & w_tc & ~w_accept),
        .i_load     (w_accept),
        .i_load_val ('0),
        .i_inc      (w_in_shift & ~w_tc),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_shreg       <= '0;
            r_sout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else if (w_accept) begin
            r_state       <= c_SHIFT;
            r_shreg       <= w_frame;
            r_sout_valid  <= 1'b1;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
        end else if (w_in_shift) begin
            r_frame_start <= 1'b0;
            if (w_tc) begin
                r_state      <= c_IDLE;
                r_shreg      <= '0;
                r_sout_valid <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                r_shreg <= w_shifted;
            end
        end
    end

    assign sout_valid  = r_sout_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Self-checking bench for piso_tx (MSB-first and LSB-first
//               instances side by side); follows PISO_PARITY_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;

    logic m_ready, m_sout, m_sv, m_fs, m_busy;
    logic l_ready, l_sout, l_sv, l_fs, l_busy;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .sout(m_sout), .sout_valid(m_sv),
        .frame_start(m_fs), .busy(m_busy)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .sout(l_sout), .sout_valid(l_sv),
        .frame_start(l_fs), .busy(l_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: the bits still to be shown for each bit order (head is
    // the bit on sout now), and whether the current cycle began a frame.
    bit q_m[$];
    bit q_l[$];
    bit exp_fs;
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    // One clock: drive inputs, check ready, advance model, check outputs.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d, output bit acc);
        bit exp_ready;
        bit par;
        rst = r; din_valid = v; din = d;
        #1;
        exp_ready = !r && (q_m.size() <= 1);
        check("din_ready_msb", m_ready, exp_ready);
        check("din_ready_lsb", l_ready, exp_ready);
        acc = v && exp_ready;
        @(posedge clk);
        cyc++;
        if (r) begin
            q_m.delete(); q_l.delete(); exp_fs = 0;
        end else if (acc) begin
            q_m.delete(); q_l.delete();
            par = ^d;
            for (int i = W - 1; i >= 0; i--) q_m.push_back(d[i]);
            for (int i = 0; i < W; i++)      q_l.push_back(d[i]);
            if (PAR) begin q_m.push_back(par); q_l.push_back(par); end
            exp_fs = 1;
        end else begin
            if (q_m.size() > 0) begin void'(q_m.pop_front()); void'(q_l.pop_front()); end
            exp_fs = 0;
        end
        @(negedge clk);
        check("sout_msb", m_sout, (q_m.size() > 0) ? q_m[0] : 1'b0);
        check("sout_lsb", l_sout, (q_l.size() > 0) ? q_l[0] : 1'b0);
        check("sout_valid_msb", m_sv, q_m.size() > 0);
        check("sout_valid_lsb", l_sv, q_l.size() > 0);
        check("busy_msb", m_busy, q_m.size() > 0);
        check("busy_lsb", l_busy, q_l.size() > 0);
        check("frame_start_msb", m_fs, exp_fs);
        check("frame_start_lsb", l_fs, exp_fs);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, acc);
    endtask

    // Present a word and hold it until accepted; reports how many cycles it waited.
    task automatic send(input logic [W-1:0] d, output int waited);
        bit acc;
        waited = 0;
        cycle(1'b0, 1'b1, d, acc);
        while (!acc && waited < 2 * FL + 4) begin
            waited++;
            cycle(1'b0, 1'b1, d, acc);
        end
        n_cmp++;
        if (!acc) begin
            n_err++;
            $error("FAIL accept_timeout cycle=%0d observed=not_accepted expected=accepted", cyc);
        end
    endtask

    initial begin
        bit acc;
        int waited;
        rst = 1'b1; din_valid = 1'b0; din = '0;
        exp_fs = 0;
        @(negedge clk);
        cycle(1'b1, 1'b0, '0, acc);
        cycle(1'b1, 1'b0, '0, acc);

        // Single frames of 0x01, then idle past the end of frame.
        send(8'h01, waited);
        idle(FL + 2);

        // Back-to-back 0xFF then 0x00 with valid held.
        send(8'hFF, waited);
        send(8'h00, waited);
        n_cmp++;
        assert (waited == FL - 1) else begin
            n_err++;
            $error("FAIL back_to_back_wait cycle=%0d observed=%0d expected=%0d", cyc, waited, FL - 1);
        end
        idle(FL + 2);

        // Abort 0xA5 with reset while bit 4 is on the line, then send 0x0F.
        send(8'hA5, waited);
        idle(4);
        cycle(1'b1, 1'b0, '0, acc);
        send(8'h0F, waited);
        n_cmp++;
        assert (waited == 0) else begin
            n_err++;
            $error("FAIL post_abort_accept cycle=%0d observed=%0d expected=0", cyc, waited);
        end
        idle(FL + 2);

        // Parity-distinguishing words.
        send(8'h07, waited);
        idle(FL + 1);

        // Reset held 3 cycles with valid asserted: accept only after release.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 8'h3C, acc);
            n_cmp++;
            assert (acc == 1'b0) else begin
                n_err++;
                $error("FAIL accept_in_reset cycle=%0d observed=1 expected=0", cyc);
            end
        end
        send(8'h3C, waited);
        n_cmp++;
        assert (waited == 0) else begin
            n_err++;
            $error("FAIL accept_after_reset cycle=%0d observed=%0d expected=0", cyc, waited);
        end
        idle(FL + 1);

        // Randomized traffic with random gaps and occasional mid-frame reset.
        for (int k = 0; k < 60; k++) begin
            send(W'($urandom), waited);
            if ($urandom_range(0, 9) == 0) begin
                idle($urandom_range(0, FL - 1));
                cycle(1'b1, $urandom_range(0, 1) == 1, W'($urandom), acc);
            end else begin
                idle($urandom_range(0, 2) == 0 ? 0 : $urandom_range(FL - 1, FL + 2));
            end
        end
        idle(FL + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
